uart_byte_receiver: RTL

UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_byte_receiver.sv | 116 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive constants and FSM encodings.
// Imported by the receiver and any future UART blocks.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int PAYLOAD_BITS_DEF = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Reset value is a parameter so idle-high lines stay quiet.
module sync_2ff #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART byte receiver, mid-bit sampling.
// Registered valid / frame-error pulses and a sticky have-byte flag.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rxd,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_frame_err,
  output logic                    rx_have_byte
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW =
    (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CW-1:0] HALF_END =
    CW'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [CW-1:0] BIT_END =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT =
    BW'(PAYLOAD_BITS - 1);

  logic                    rxd_s;
  logic [2:0]              state;
  logic [CW-1:0]           cyc_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic                    half_tick;
  logic                    bit_tick;

  sync_2ff #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_rxd),
    .q   (rxd_s)
  );

  assign half_tick = (cyc_cnt == HALF_END);
  assign bit_tick  = (cyc_cnt == BIT_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      cyc_cnt           <= '0;
      bit_cnt           <= '0;
      shreg             <= '0;
      uart_rx_data      <= '0;
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      rx_have_byte      <= 1'b0;
    end else begin
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          if (!rxd_s)
            state <= ST_START;
        end
        ST_START: begin
          if (half_tick) begin
            cyc_cnt <= '0;
            state   <= rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            cyc_cnt <= '0;
            // LSB arrives first, so shift right.
            shreg   <= {rxd_s, shreg[PAYLOAD_BITS-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == LAST_BIT)
              state <= ST_STOP;
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            cyc_cnt <= '0;
            if (rxd_s) begin
              uart_rx_data  <= shreg;
              uart_rx_valid <= 1'b1;
              rx_have_byte  <= 1'b1;
              state         <= ST_IDLE;
            end else begin
              uart_rx_frame_err <= 1'b1;
              state             <= ST_WAIT_HIGH;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          // A break keeps us here: one error per low period.
          if (rxd_s)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
